hazard_forward_ctrl: RTL and testbench

//  Hazard and forwarding controller for the 5-stage pipeline. Tracks destination info of

---
 rtl/hazard_forward_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_ctrl
// Description : Hazard and forwarding controller for a 5-stage pipeline.
//               Mirrors the destination info of the EX/MEM/WB instructions,
//               drives both EX operand forwarding mux selects, and raises
//               load-use / RAW stalls, bubbles and branch flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_ctrl #(
    parameter int REG_W  = 5,
    parameter int FWD_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic [1:0]       id_res_src,
    input  logic             ex_branch_tk,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [2:0]       fwd_a_sel,
    output logic [2:0]       fwd_b_sel,
    output logic [15:0]      stall_cnt
);

    // Result source encoding of the decoded instruction
    localparam logic [1:0] c_RES_ALU  = 2'b00;
    localparam logic [1:0] c_RES_LOAD = 2'b01;
    localparam logic [1:0] c_RES_PC4  = 2'b10;

    // Operand mux select encoding
    localparam logic [2:0] c_SEL_RF      = 3'b000;
    localparam logic [2:0] c_SEL_MEM_ALU = 3'b001;
    localparam logic [2:0] c_SEL_WB      = 3'b010;
    localparam logic [2:0] c_SEL_MEM_PC4 = 3'b011;
    localparam logic [2:0] c_SEL_MEM_IMM = 3'b100;

    localparam logic [REG_W-1:0] c_REG_ZERO = '0;
    localparam logic [15:0]      c_CNT_MAX  = 16'hFFFF;

    // Stall FSM state encoding
    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_STALL = 1'b1;

    // EX stage record (consumer fields are needed here for forwarding)
    logic             r_ex_valid;
    logic [REG_W-1:0] r_ex_rs1;
    logic [REG_W-1:0] r_ex_rs2;
    logic [REG_W-1:0] r_ex_rd;
    logic             r_ex_rw;
    logic [1:0]       r_ex_res;
    // MEM stage record (producer fields only)
    logic             r_mem_valid;
    logic [REG_W-1:0] r_mem_rd;
    logic             r_mem_rw;
    logic [1:0]       r_mem_res;
    // WB stage record (result always comes from the WB mux, so no res_src)
    logic             r_wb_valid;
    logic [REG_W-1:0] r_wb_rd;
    logic             r_wb_rw;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [15:0] r_stall_cnt;

    logic       w_ex_prod;
    logic       w_mem_prod;
    logic       w_wb_prod;
    logic       w_ex_uses;
    logic       w_mem_uses;
    logic       w_hazard;
    logic       w_stall;
    logic       w_flush_d;
    logic       w_flush_e;
    logic [2:0] w_fwd_a;
    logic [2:0] w_fwd_b;

    // Forwarding source for one EX operand; a load sitting in MEM has no
    // data yet, so it is skipped and only the WB producer is considered.
    function automatic logic [2:0] f_fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic             mem_prod,
        input logic [REG_W-1:0] mem_rd,
        input logic [1:0]       mem_res,
        input logic             wb_prod,
        input logic [REG_W-1:0] wb_rd
    );
        logic [2:0] sel;
        sel = c_SEL_RF;
        if (rs != c_REG_ZERO) begin
            if (mem_prod && (mem_rd == rs) && (mem_res != c_RES_LOAD)) begin
                case (mem_res)
                    c_RES_ALU: sel = c_SEL_MEM_ALU;
                    c_RES_PC4: sel = c_SEL_MEM_PC4;
                    default:   sel = c_SEL_MEM_IMM;
                endcase
            end else if (wb_prod && (wb_rd == rs)) begin
                sel = c_SEL_WB;
            end
        end
        return sel;
    endfunction

    // A stage is a producer when it really writes a non-zero register
    assign w_ex_prod  = r_ex_valid  & r_ex_rw  & (r_ex_rd  != c_REG_ZERO);
    assign w_mem_prod = r_mem_valid & r_mem_rw & (r_mem_rd != c_REG_ZERO);
    assign w_wb_prod  = r_wb_valid  & r_wb_rw  & (r_wb_rd  != c_REG_ZERO);

    // rs2 is compared for every format; spurious stalls are harmless
    assign w_ex_uses  = (r_ex_rd  == id_rs1) | (r_ex_rd  == id_rs2);
    assign w_mem_uses = (r_mem_rd == id_rs1) | (r_mem_rd == id_rs2);

    if (FWD_EN != 0) begin : g_fwd
        // Only a load in EX cannot be covered by forwarding
        assign w_hazard = id_valid & r_ex_valid & (r_ex_res == c_RES_LOAD) &
                          (r_ex_rd != c_REG_ZERO) & w_ex_uses;
        assign w_fwd_a  = f_fwd_sel(r_ex_rs1, w_mem_prod, r_mem_rd, r_mem_res,
                                    w_wb_prod, r_wb_rd);
        assign w_fwd_b  = f_fwd_sel(r_ex_rs2, w_mem_prod, r_mem_rd, r_mem_res,
                                    w_wb_prod, r_wb_rd);
    end else begin : g_nofwd
        // Without forwarding any EX/MEM producer must drain first; WB is
        // covered by the write-first register file
        assign w_hazard = id_valid & ((w_ex_prod & w_ex_uses) |
                                      (w_mem_prod & w_mem_uses));
        assign w_fwd_a  = c_SEL_RF;
        assign w_fwd_b  = c_SEL_RF;
    end

    // Advance the stage records; a flushed EX slot becomes an all-zero bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid  <= 1'b0;
            r_ex_rs1    <= c_REG_ZERO;
            r_ex_rs2    <= c_REG_ZERO;
            r_ex_rd     <= c_REG_ZERO;
            r_ex_rw     <= 1'b0;
            r_ex_res    <= c_RES_ALU;
            r_mem_valid <= 1'b0;
            r_mem_rd    <= c_REG_ZERO;
            r_mem_rw    <= 1'b0;
            r_mem_res   <= c_RES_ALU;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= c_REG_ZERO;
            r_wb_rw     <= 1'b0;
        end else begin
            r_wb_valid  <= r_mem_valid;
            r_wb_rd     <= r_mem_rd;
            r_wb_rw     <= r_mem_rw;
            r_mem_valid <= r_ex_valid;
            r_mem_rd    <= r_ex_rd;
            r_mem_rw    <= r_ex_rw;
            r_mem_res   <= r_ex_res;
            if (w_flush_e) begin
                r_ex_valid <= 1'b0;
                r_ex_rs1   <= c_REG_ZERO;
                r_ex_rs2   <= c_REG_ZERO;
                r_ex_rd    <= c_REG_ZERO;
                r_ex_rw    <= 1'b0;
                r_ex_res   <= c_RES_ALU;
            end else begin
                r_ex_valid <= id_valid;
                r_ex_rs1   <= id_rs1;
                r_ex_rs2   <= id_rs2;
                r_ex_rd    <= id_rd;
                r_ex_rw    <= id_reg_write;
                r_ex_res   <= id_res_src;
            end
        end
    end

    // Stall FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stall FSM next state; a taken branch always returns to RUN
    always_comb begin
        w_state_nxt = r_state;
        if (ex_branch_tk) begin
            w_state_nxt = c_ST_RUN;
        end else begin
            case (r_state)
                c_ST_RUN:   w_state_nxt = w_hazard ? c_ST_STALL : c_ST_RUN;
                c_ST_STALL: w_state_nxt = w_hazard ? c_ST_STALL : c_ST_RUN;
                default:    w_state_nxt = c_ST_RUN;
            endcase
        end
    end

    // Stall/flush outputs follow the current-cycle hazard in both states
    always_comb begin
        w_stall   = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        if (!reset) begin
            if (ex_branch_tk) begin
                w_flush_d = 1'b1;
                w_flush_e = 1'b1;
            end else if (w_hazard) begin
                w_stall   = 1'b1;
                w_flush_e = 1'b1;
            end
        end
    end

    // Saturating count of cycles with the decode stage held
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_f   = w_stall;
    assign stall_d   = w_stall;
    assign flush_d   = w_flush_d;
    assign flush_e   = w_flush_e;
    assign fwd_a_sel = w_fwd_a;
    assign fwd_b_sel = w_fwd_b;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_ctrl
// Description : Self-checking bench for hazard_forward_ctrl. Two instances run
//               side by side (forwarding on / off) from shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic [1:0] res;
    } rec_t;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic [1:0] id_res_src;
    logic       ex_branch_tk;

    logic        a1_stall_f, a1_stall_d, a1_flush_d, a1_flush_e;
    logic [2:0]  a1_fwd_a, a1_fwd_b;
    logic [15:0] a1_cnt;
    logic        a0_stall_f, a0_stall_d, a0_flush_d, a0_flush_e;
    logic [2:0]  a0_fwd_a, a0_fwd_b;
    logic [15:0] a0_cnt;

    logic [3:0]  f1_ctl, f0_ctl;
    logic [25:0] v1, v0;
    assign f1_ctl = {a1_stall_f, a1_stall_d, a1_flush_d, a1_flush_e};
    assign f0_ctl = {a0_stall_f, a0_stall_d, a0_flush_d, a0_flush_e};
    assign v1 = {f1_ctl, a1_fwd_a, a1_fwd_b, a1_cnt};
    assign v0 = {f0_ctl, a0_fwd_a, a0_fwd_b, a0_cnt};

    int n_checks = 0;
    int n_pass   = 0;

    // Reference pipeline: [instance][0=EX,1=MEM,2=WB]
    rec_t pipe [2][3];
    int   m_cnt [2];

    hazard_forward_ctrl #(.REG_W(5), .FWD_EN(1)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_res_src(id_res_src), .ex_branch_tk(ex_branch_tk),
        .stall_f(a1_stall_f), .stall_d(a1_stall_d), .flush_d(a1_flush_d),
        .flush_e(a1_flush_e), .fwd_a_sel(a1_fwd_a), .fwd_b_sel(a1_fwd_b),
        .stall_cnt(a1_cnt)
    );

    hazard_forward_ctrl #(.REG_W(5), .FWD_EN(0)) dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_res_src(id_res_src), .ex_branch_tk(ex_branch_tk),
        .stall_f(a0_stall_f), .stall_d(a0_stall_d), .flush_d(a0_flush_d),
        .flush_e(a0_flush_e), .fwd_a_sel(a0_fwd_a), .fwd_b_sel(a0_fwd_b),
        .stall_cnt(a0_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic [1:0] res);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = rw; id_res_src = res;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        ex_branch_tk = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_live(input rec_t r);
        return r.v && r.rw && (r.rd != 5'd0);
    endfunction

    function automatic bit m_reads(input rec_t r);
        return (r.rd == id_rs1) || (r.rd == id_rs2);
    endfunction

    function automatic bit m_hazard(input int f);
        if (!id_valid) return 1'b0;
        if (f == 1)
            return pipe[1][0].v && (pipe[1][0].res == 2'b01) &&
                   (pipe[1][0].rd != 5'd0) && m_reads(pipe[1][0]);
        return (m_live(pipe[0][0]) && m_reads(pipe[0][0])) ||
               (m_live(pipe[0][1]) && m_reads(pipe[0][1]));
    endfunction

    function automatic logic [2:0] m_sel(input int f, input logic [4:0] rs);
        rec_t mem, wb;
        mem = pipe[f][1];
        wb  = pipe[f][2];
        if (f == 0 || rs == 5'd0) return 3'b000;
        if (m_live(mem) && mem.rd == rs && mem.res != 2'b01)
            return (mem.res == 2'b00) ? 3'b001 : (mem.res == 2'b10) ? 3'b011 : 3'b100;
        if (m_live(wb) && wb.rd == rs) return 3'b010;
        return 3'b000;
    endfunction

    function automatic logic [25:0] m_expect(input int f);
        bit hz, st, br;
        hz = m_hazard(f);
        br = ex_branch_tk;
        st = hz && !br;
        return {st, st, br, (br || st), m_sel(f, pipe[f][0].rs1),
                m_sel(f, pipe[f][0].rs2), m_cnt[f][15:0]};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        set_id(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 2'b01);
        ex_branch_tk = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        n_checks++; if (v1 !== 26'd0) $display("FAIL reset_fwd1: got %h exp 0", v1); else n_pass++;
        n_checks++; if (v0 !== 26'd0) $display("FAIL reset_fwd0: got %h exp 0", v0); else n_pass++;
    endtask

    task automatic test_alu_forward();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 2'b00);
        @(negedge clk);
        set_id(1'b1, 5'd5, 5'd3, 5'd10, 1'b1, 2'b00);
        #1;
        n_checks++; if (f1_ctl !== 4'b0000) $display("FAIL alu_nostall: got %b exp 0000", f1_ctl); else n_pass++;
        @(negedge clk);
        idle();
        #1;
        n_checks++; if (a1_fwd_a !== 3'b001) $display("FAIL alu_fwd_a: got %b exp 001", a1_fwd_a); else n_pass++;
        n_checks++; if (a1_fwd_b !== 3'b000) $display("FAIL alu_fwd_b: got %b exp 000", a1_fwd_b); else n_pass++;
        n_checks++; if (a1_cnt !== 16'd0) $display("FAIL alu_cnt: got %0d exp 0", a1_cnt); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 2'b01);
        @(negedge clk);
        set_id(1'b1, 5'd2, 5'd6, 5'd11, 1'b1, 2'b00);
        #1;
        n_checks++; if (f1_ctl !== 4'b1101) $display("FAIL lu_stall: got %b exp 1101", f1_ctl); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (f1_ctl !== 4'b0000) $display("FAIL lu_release: got %b exp 0000", f1_ctl); else n_pass++;
        @(negedge clk);
        idle();
        #1;
        n_checks++; if (a1_fwd_b !== 3'b010) $display("FAIL lu_fwd_b: got %b exp 010", a1_fwd_b); else n_pass++;
        n_checks++; if (a1_fwd_a !== 3'b000) $display("FAIL lu_fwd_a: got %b exp 000", a1_fwd_a); else n_pass++;
        n_checks++; if (a1_cnt !== 16'd1) $display("FAIL lu_cnt: got %0d exp 1", a1_cnt); else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        set_id(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 2'b00);   // addi x7
        @(negedge clk);
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 2'b11);   // lui x7
        @(negedge clk);
        set_id(1'b1, 5'd7, 5'd1, 5'd12, 1'b1, 2'b00);  // consumer of x7
        @(negedge clk);
        set_id(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 2'b10);   // jal x1
        #1;
        n_checks++; if (a1_fwd_a !== 3'b100) $display("FAIL prio_mem_imm: got %b exp 100", a1_fwd_a); else n_pass++;
        n_checks++; if (a1_fwd_b !== 3'b000) $display("FAIL prio_b_none: got %b exp 000", a1_fwd_b); else n_pass++;
        @(negedge clk);
        set_id(1'b1, 5'd12, 5'd1, 5'd13, 1'b1, 2'b00); // reads x12, x1
        @(negedge clk);
        idle();
        #1;
        n_checks++; if (a1_fwd_b !== 3'b011) $display("FAIL prio_mem_pc4: got %b exp 011", a1_fwd_b); else n_pass++;
        n_checks++; if (a1_fwd_a !== 3'b010) $display("FAIL prio_wb: got %b exp 010", a1_fwd_a); else n_pass++;
    endtask

    task automatic test_x0_and_branch();
        do_reset();
        set_id(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 2'b00);
        @(negedge clk);
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 2'b11);
        @(negedge clk);
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 2'b00);
        @(negedge clk);
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 2'b01);   // lw x0
        #1;
        n_checks++; if ({a1_fwd_a, a1_fwd_b} !== 6'b0) $display("FAIL x0_sel: got %b exp 000000", {a1_fwd_a, a1_fwd_b}); else n_pass++;
        @(negedge clk);
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 2'b00);
        #1;
        n_checks++; if (f1_ctl !== 4'b0000) $display("FAIL x0_load_nostall: got %b exp 0000", f1_ctl); else n_pass++;
        @(negedge clk);
        set_id(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 2'b01);   // lw x8
        @(negedge clk);
        set_id(1'b1, 5'd8, 5'd2, 5'd9, 1'b1, 2'b00);
        ex_branch_tk = 1'b1;
        #1;
        n_checks++; if (f1_ctl !== 4'b0011) $display("FAIL br_override: got %b exp 0011", f1_ctl); else n_pass++;
        @(negedge clk);
        ex_branch_tk = 1'b0;
        #1;
        n_checks++; if (f1_ctl !== 4'b0000) $display("FAIL br_after: got %b exp 0000", f1_ctl); else n_pass++;
        n_checks++; if (a1_cnt !== 16'd0) $display("FAIL br_cnt: got %0d exp 0", a1_cnt); else n_pass++;
    endtask

    task automatic test_no_forward();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 2'b00);   // add x9
        @(negedge clk);
        set_id(1'b1, 5'd9, 5'd3, 5'd14, 1'b1, 2'b00);
        #1;
        n_checks++; if (f0_ctl !== 4'b1101) $display("FAIL nf_stall1: got %b exp 1101", f0_ctl); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (f0_ctl !== 4'b1101) $display("FAIL nf_stall2: got %b exp 1101", f0_ctl); else n_pass++;
        n_checks++; if ({a0_fwd_a, a0_fwd_b} !== 6'b0) $display("FAIL nf_sel_mid: got %b exp 000000", {a0_fwd_a, a0_fwd_b}); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (f0_ctl !== 4'b0000) $display("FAIL nf_release: got %b exp 0000", f0_ctl); else n_pass++;
        @(negedge clk);
        idle();
        #1;
        n_checks++; if ({a0_fwd_a, a0_fwd_b} !== 6'b0) $display("FAIL nf_sel: got %b exp 000000", {a0_fwd_a, a0_fwd_b}); else n_pass++;
        n_checks++; if (a0_cnt !== 16'd2) $display("FAIL nf_cnt: got %0d exp 2", a0_cnt); else n_pass++;
    endtask

    task automatic test_saturation();
        // Pin a matching producer in EX so the hazard never clears
        @(negedge clk);
        set_id(1'b1, 5'd9, 5'd0, 5'd15, 1'b1, 2'b00);
        force dut0.r_ex_valid = 1'b1;
        force dut0.r_ex_rw    = 1'b1;
        force dut0.r_ex_rd    = 5'd9;
        repeat (70000) @(negedge clk);
        #1;
        n_checks++; if (a0_cnt !== 16'hFFFF) $display("FAIL sat_cnt: got %h exp ffff", a0_cnt); else n_pass++;
        n_checks++; if (a0_stall_d !== 1'b1) $display("FAIL sat_stall: got %b exp 1", a0_stall_d); else n_pass++;
        release dut0.r_ex_valid;
        release dut0.r_ex_rw;
        release dut0.r_ex_rd;
        do_reset();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 2'b00);
        @(negedge clk);
        set_id(1'b1, 5'd9, 5'd3, 5'd14, 1'b1, 2'b00);
        #1;
        n_checks++; if (f0_ctl !== 4'b1101) $display("FAIL rms_enter: got %b exp 1101", f0_ctl); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (v0 !== 26'd0) $display("FAIL rms_outputs: got %h exp 0", v0); else n_pass++;
        n_checks++; if (dut0.r_state !== 1'b0) $display("FAIL rms_state: got %b exp 0", dut0.r_state); else n_pass++;
    endtask

    task automatic test_random();
        rec_t idr;
        bit   st [2];
        bit   fl [2];
        logic [25:0] exp_v;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < 3; s++) pipe[f][s] = '0;
            m_cnt[f] = 0;
        end
        for (int i = 0; i < 3000; i++) begin
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            ex_branch_tk = ($urandom_range(0, 7) == 0);
            #1;
            for (int f = 0; f < 2; f++) begin
                exp_v = m_expect(f);
                st[f] = exp_v[25];
                fl[f] = exp_v[22];
                n_checks++;
                if (((f == 1) ? v1 : v0) !== exp_v)
                    $display("FAIL rand_fwd%0d cycle %0d: got %h exp %h", f, i,
                             (f == 1) ? v1 : v0, exp_v);
                else
                    n_pass++;
            end
            idr = '{v: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                    rw: id_reg_write, res: id_res_src};
            @(posedge clk);
            for (int f = 0; f < 2; f++) begin
                pipe[f][2] = pipe[f][1];
                pipe[f][1] = pipe[f][0];
                pipe[f][0] = fl[f] ? '0 : idr;
                if (st[f] && m_cnt[f] < 65535) m_cnt[f]++;
            end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_priority();
        test_x0_and_branch();
        test_no_forward();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
